// File: rtl/fp_div_arbiter.sv
// ============================================================================
// Module      : fp_div_arbiter
// Description : Shares one serial floating-point divider among N_REQ clients.
//               The block arbitrates round-robin and latches the operands.
//               It sends a one-cycle start pulse to the divider, captures the
//               result and returns it over a valid/ready response. A watchdog
//               forces an error response if the divider never reports done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester side
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*32-1:0]   req_op_a_i,
  input  logic [N_REQ*32-1:0]   req_op_b_i,
  // response side
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [31:0]           rsp_res_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  // divider side
  output logic                  div_start_o,
  output logic [31:0]           div_op_a_o,
  output logic [31:0]           div_op_b_o,
  input  logic                  div_done_i,
  input  logic [31:0]           div_res_i
);

  // The watchdog counter must be able to hold TIMEOUT itself.
  localparam int                CNT_W       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  CNT_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [ID_W-1:0]   LAST_ID     = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;          // highest-priority requester
  logic [ID_W-1:0]     gnt_q, gnt_d;        // owner of the operation in flight
  logic [31:0]         op_a_q, op_a_d;
  logic [31:0]         op_b_q, op_b_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [31:0]         res_q, res_d;
  logic                err_q, err_d;

  logic                w_any;
  logic [ID_W-1:0]     w_gnt;
  logic [N_REQ-1:0]    w_onehot;
  logic [31:0]         w_op_a;
  logic [31:0]         w_op_b;

  assign w_any = |req_valid_i;

  // Round-robin pick. The first pass finds the lowest valid index overall.
  // The second pass overrides it with the lowest valid index at or above
  // rr_q. This is the same as a circular search that starts at rr_q.
  always_comb begin
    w_gnt = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        w_gnt = ID_W'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i] && (i >= int'(rr_q))) begin
        w_gnt = ID_W'(i);
      end
    end
  end

  // Decode the winner into a one-hot ready vector and select its operands.
  always_comb begin
    w_onehot = '0;
    w_op_a   = '0;
    w_op_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_op_a      = req_op_a_i[32*i +: 32];
        w_op_b      = req_op_b_i[32*i +: 32];
      end
    end
  end

  // Ready is only offered while idle. It is also held low during reset, so
  // a requester already asserting valid sees no accept while rst is high.
  // rsp_ready_i does not reach this path.
  assign req_ready_o = ((state_q == ST_IDLE) && !rst && w_any) ? w_onehot : '0;

  assign busy_o      = (state_q != ST_IDLE);
  assign div_start_o = (state_q == ST_ISSUE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_id_o    = gnt_q;
  assign rsp_res_o   = res_q;
  assign rsp_err_o   = err_q;
  assign div_op_a_o  = op_a_q;
  assign div_op_b_o  = op_b_q;

  // Next-state and datapath-update logic for the arbitration sequence.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    wait_cnt_d = wait_cnt_q;
    res_d      = res_q;
    err_d      = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          gnt_d   = w_gnt;
          op_a_d  = w_op_a;
          op_b_d  = w_op_b;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        // The divider's done is still high from its previous idle period in
        // the first WAIT cycle. It is only trusted once the count has moved.
        if (div_done_i && (wait_cnt_q != '0)) begin
          res_d   = div_res_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wait_cnt_q == CNT_TIMEOUT) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // Fairness only advances on the handshake. A timed-out owner also
        // gives up its turn.
        if (rsp_ready_i) begin
          rr_d    = (gnt_q == LAST_ID) ? '0 : gnt_q + ID_W'(1);
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      gnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      wait_cnt_q <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      wait_cnt_q <= wait_cnt_d;
      res_q      <= res_d;
      err_q      <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_div_arbiter.sv
// ============================================================================
// Module      : tb_fp_div_arbiter
// Description : Self-checking bench for fp_div_arbiter. It uses a stub
//               divider (result = a ^ b, 50-cycle latency) and a
//               transaction-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp_div_arbiter;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 255;
  localparam int LAT     = 50;

  localparam int MODE_NORMAL = 0;  // done low for LAT cycles after start
  localparam int MODE_LATE   = 1;  // done stays high one extra cycle first
  localparam int MODE_STUCK  = 2;  // done never asserts

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_REQ-1:0]      req_valid = '0;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*32-1:0]   req_op_a = '0;
  logic [N_REQ*32-1:0]   req_op_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_res;
  logic                  rsp_err;
  logic                  busy;
  logic                  div_start;
  logic [31:0]           div_op_a;
  logic [31:0]           div_op_b;
  logic                  div_done;
  logic [31:0]           div_res;

  fp_div_arbiter #(
    .N_REQ   (N_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_a_i  (req_op_a),
    .req_op_b_i  (req_op_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_res_o   (rsp_res),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .div_start_o (div_start),
    .div_op_a_o  (div_op_a),
    .div_op_b_o  (div_op_b),
    .div_done_i  (div_done),
    .div_res_i   (div_res)
  );

  always #5 clk = ~clk;

  // Stub divider. Done is high while idle and low for LAT cycles after a start.
  int stub_mode = MODE_NORMAL;
  int stub_pend;
  int stub_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_pend <= 0;
      stub_cnt  <= 0;
    end else if (div_start) begin
      stub_pend <= (stub_mode == MODE_LATE) ? 1 : 0;
      stub_cnt  <= LAT;
    end else if (stub_pend > 0) begin
      stub_pend <= stub_pend - 1;
    end else if (stub_cnt > 0) begin
      stub_cnt  <= stub_cnt - 1;
    end
  end
  assign div_done = (stub_mode != MODE_STUCK) && ((stub_pend > 0) || (stub_cnt == 0));
  assign div_res  = div_op_a ^ div_op_b;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to the sample point of the next cycle (2 ns after the rising edge).
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: round-robin pointer advanced on every completed response.
  int rr_model = 0;
  int grants_seen[$];
  logic [31:0] last_res;

  function automatic int model_grant(input logic [N_REQ-1:0] mask);
    for (int k = 0; k < N_REQ; k++) begin
      if (mask[(rr_model + k) % N_REQ]) return (rr_model + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One full request/response transaction. It starts and ends at the sample
  // point of an idle cycle.
  task automatic txn(input logic [N_REQ-1:0] mask, input int mode, input int hold,
                     input bit rand_ops);
    int          g;
    int          cyc;
    int          exp_lat;
    logic [31:0] ea, eb;
    logic [ID_W-1:0] hid;
    logic [31:0] hres;
    logic        herr;
    logic        bad_start, bad_ready, bad_ops, bad_hold;
    bad_start = 1'b0; bad_ready = 1'b0; bad_ops = 1'b0; bad_hold = 1'b0;
    stub_mode = mode;
    if (rand_ops) begin
      for (int i = 0; i < N_REQ; i++) begin
        req_op_a[32*i +: 32] = $urandom;
        req_op_b[32*i +: 32] = $urandom;
      end
    end
    req_valid = mask;
    rsp_ready = (hold == 0);
    #1;
    g = model_grant(mask);
    check("idle_busy", busy, 0);
    check("grant", req_ready, 64'(1) << g);
    grants_seen.push_back(onehot_idx(req_ready));
    ea = req_op_a[32*g +: 32];
    eb = req_op_b[32*g +: 32];
    tick();
    // cycle 1: the start pulse carries the granted operands
    check("start", div_start, 1);
    check("op_a", div_op_a, ea);
    check("op_b", div_op_b, eb);
    check("issue_ready", req_ready, 0);
    cyc = 1;
    while (!rsp_valid && cyc < TIMEOUT + 20) begin
      tick();
      cyc++;
      if (div_start) bad_start = 1'b1;
      if (req_ready != '0) bad_ready = 1'b1;
      if (div_op_a !== ea || div_op_b !== eb) bad_ops = 1'b1;
    end
    // Response timing, counted from the accept cycle. The start pulse is in
    // cycle 1 and WAIT begins in cycle 2 with its count at 0. The first
    // usable done (or the count reaching TIMEOUT) is registered one cycle
    // later.
    case (mode)
      MODE_NORMAL: exp_lat = LAT + 3;
      MODE_LATE:   exp_lat = LAT + 4;
      default:     exp_lat = TIMEOUT + 3;
    endcase
    check("latency", cyc, exp_lat);
    check("single_start", bad_start, 0);
    check("wait_ready", bad_ready, 0);
    check("ops_stable", bad_ops, 0);
    check("rsp_id", rsp_id, g);
    check("rsp_err", rsp_err, (mode == MODE_STUCK) ? 1 : 0);
    check("rsp_res", rsp_res, (mode == MODE_STUCK) ? 32'h0 : (ea ^ eb));
    last_res = rsp_res;
    hid = rsp_id; hres = rsp_res; herr = rsp_err;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (!rsp_valid || rsp_id !== hid || rsp_res !== hres || rsp_err !== herr ||
          req_ready != '0 || div_start) bad_hold = 1'b1;
    end
    check("resp_hold", bad_hold, 0);
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    check("rsp_drop", rsp_valid, 0);
    check("back_idle", busy, 0);
    rr_model = (g + 1) % N_REQ;
  endtask

  // Asynchronous reset in the middle of WAIT: everything clears at once and
  // no response follows.
  task automatic reset_in_wait();
    logic saw_rsp;
    saw_rsp   = 1'b0;
    stub_mode = MODE_NORMAL;
    for (int i = 0; i < N_REQ; i++) begin
      req_op_a[32*i +: 32] = $urandom;
      req_op_b[32*i +: 32] = $urandom;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    check("rst_pre_grant", req_ready, 64'(1) << model_grant('1));
    repeat (22) tick();  // accept is cycle 0, WAIT count reaches 20 in cycle 22
    check("rst_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_outs_zero",
          ({req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, busy, div_start} != '0), 0);
    check("rst_ops_zero", {div_op_a, div_op_b}, 0);
    req_valid = '0;
    repeat (3) tick();
    rst = 1'b0;
    rr_model = 0;
    repeat (LAT + 10) begin
      tick();
      if (rsp_valid || busy) saw_rsp = 1'b1;
    end
    check("rst_no_resp", saw_rsp, 0);
  endtask

  int exp_order[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 3};

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset_outs",
          ({req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, busy, div_start} != '0), 0);
    check("reset_ops", {div_op_a, div_op_b}, 0);
    req_valid = '1;
    #1;
    check("reset_ready_gated", req_ready, 0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();

    // Fairness: all requesters valid, then only 0 and 3 right after grant 3
    grants_seen.delete();
    repeat (8) txn(4'b1111, MODE_NORMAL, 0, 1'b1);
    repeat (2) txn(4'b1001, MODE_NORMAL, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rr_order_%0d", i), (i < grants_seen.size()) ? grants_seen[i] : -1,
            exp_order[i]);
    end

    // Directed single request from requester 1
    req_op_a[63:32] = 32'h40C00000;
    req_op_b[63:32] = 32'h40000000;
    txn(4'b0010, MODE_NORMAL, 0, 1'b0);
    check("t1_quotient", last_res, 32'h00C00000);

    // Response back-pressure for 10 cycles
    txn(4'($urandom_range(1, 15)), MODE_NORMAL, 10, 1'b1);
    // The stale done after start must be ignored
    txn(4'($urandom_range(1, 15)), MODE_LATE, 0, 1'b1);
    // Watchdog timeout
    txn(4'($urandom_range(1, 15)), MODE_STUCK, 2, 1'b1);

    // Reset mid-WAIT, then a normal request granted from pointer 0
    reset_in_wait();
    txn(4'($urandom_range(1, 15)), MODE_NORMAL, 0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 12; n++) begin
      txn(4'($urandom_range(1, 15)),
          ($urandom_range(0, 3) == 0) ? MODE_LATE : MODE_NORMAL,
          int'($urandom_range(0, 3)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
